iir_biquad_tdm: RTL
===================

# iir_biquad_tdm

Time-multiplexed, multi-channel second-order (biquad) IIR filter in signed fixed point. One shared multiply-accumulate datapath serves CHANNELS independent channels, each with its own delay state and runtime-writable coefficients. Sits in the filter chain between the sample source and the output stage, and generalises the first-order single-channel filter to second order, N channels, a parametrised width and a valid/ready input handshake.

## Interface
- DATA_W, 16: sample and coefficient width, two's complement.
- FRAC_W, 14: fractional bits; 1.0 = 1<<FRAC_W. Requires FRAC_W ≤ DATA_W-2.
- CHANNELS, 4: channel count, ≥1; CH_W = max(1, clog2(CHANNELS)).
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  sample offered.
- in_ready  out  1  core can accept a sample.
- in_ch  in  CH_W  channel of offered sample.
- x  in  DATA_W  input sample.
- coef_we  in  1  coefficient write strobe.
- coef_ch  in  CH_W  channel to write.
- coef_sel  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 ignored.
- coef_data  in  DATA_W  coefficient value.
- out_valid  out  1  one-cycle pulse, y valid.
- out_ch  out  CH_W  channel of y.
- y  out  DATA_W  filtered sample.

## Operation
- Direct form II per channel: w = x − a1·w1 − a2·w2; y = b0·w + b1·w1 + b2·w2; then w2←w1, w1←w.
- Accumulator width 2·DATA_W+3. x enters as x<<FRAC_W. Each product is full 2·DATA_W signed.
- Quantisation of w and y: add 1<<(FRAC_W−1), arithmetic shift right FRAC_W, then reduce to DATA_W (saturate or wrap, see Configuration).
- FSM: IDLE → FB1 → FB2 → FF0 → FF1 → FF2 → DONE → IDLE.
  - IDLE: in_ready=1; on in_valid, latch x, in_ch and that channel's five coefficients, w1 and w2 into working registers.
  - FB1: acc = (x<<FRAC_W) − a1·w1. FB2: acc −= a2·w2. Quantise into w at the end of FB2.
  - FF0: acc = b0·w. FF1: += b1·w1. FF2: += b2·w2.
  - DONE: quantise acc into y, pulse out_valid, write back w1/w2 for the channel.
- Coefficient writes apply in the cycle of coef_we, in any state. Because coefficients are latched at accept, a write to the channel in flight affects only its next sample. coef_ch ≥ CHANNELS or coef_sel ≥ 5: write ignored.
- in_ch ≥ CHANNELS: the sample is accepted and the FSM runs, but out_valid stays 0 and no state is written.
- Reset values:
  - All w1/w2 = 0.
  - b0 = 1<<FRAC_W; b1, b2, a1, a2 = 0 (passthrough).
  - out_valid=0, y=0, out_ch=0, FSM=IDLE, in_ready=1 in the cycle after rst deasserts.

## Timing
- Handshake on the cycle where in_valid & in_ready.
- Accept at cycle N: FB1 at N+1, FF0 at N+3, DONE at N+6. out_valid=1 during N+6 only. y and out_ch hold until the next DONE.
- in_ready=0 from N+1 through N+6. The next accept is no earlier than N+7, giving a throughput of 1 sample per 7 cycles.
- Downstream has no backpressure; out_valid is never stalled.
- rst asserted in any state aborts the sample: no out_valid, no state write-back, all registers return to reset values.

## Configuration
- IIR_SATURATE_EN defined: quantised w and y clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- IIR_SATURATE_EN undefined: the low DATA_W bits are kept (two's complement wrap).

## Test plan
All values below use the default parameters.
- Reset passthrough: ch0, x=0x1000 → out_valid exactly 6 cycles after accept, y=0x1000, out_ch=0.
- Recursion: ch1 b0=0x2000, a1=0xE000; impulse x=0x4000, 0, 0 → y=0x2000, 0x1000, 0x0800.
- Channel isolation: interleave ch0 samples (x=0x0100) between the ch1 impulse samples → ch1 outputs unchanged; ch0 y=0x0100 each time.
- Overflow: ch2 b0=b1=0x4000, x=0x7000 twice → first y=0x7000; second y=0x7FFF with IIR_SATURATE_EN, 0xE000 without.
- Mid-sample coefficient write: ch0 accept x=0x1000, then write b0=0 at FB1 → that sample y=0x1000; the next ch0 sample gives y=0.
- Reset mid-operation: rst for one cycle during FF0 → no out_valid for that sample; in_ready=1 the cycle after rst deasserts; the next ch0 x=0x1000 gives y=0x1000.

Source files
------------

// File: rtl/iir_biquad_tdm.sv
// Time-multiplexed N-channel direct-form-II biquad sharing one multiplier; 7 cycles per sample.
// Define IIR_SATURATE_EN to clamp quantised w/y instead of wrapping to DATA_W bits.
module iir_biquad_tdm #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 14,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] x,
  input  logic              coef_we,
  input  logic [CH_W-1:0]   coef_ch,
  input  logic [2:0]        coef_sel,
  input  logic [DATA_W-1:0] coef_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] y
);

  localparam int ACC_W  = 2 * DATA_W + 3;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1) << (FRAC_W - 1);
  localparam logic        [DATA_W-1:0] COEF_ONE = DATA_W'(1) << FRAC_W;
`ifdef IIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) << (DATA_W - 1));
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FB1  = 3'd1,
    FB2  = 3'd2,
    FF0  = 3'd3,
    FF1  = 3'd4,
    FF2  = 3'd5,
    DONE = 3'd6
  } state_t;

  function automatic logic [DATA_W-1:0] quant(input logic signed [ACC_W-1:0] a);
`ifdef IIR_SATURATE_EN
    logic signed [ACC_W-1:0] s;
    s = (a + RND) >>> FRAC_W;
    if (s > SAT_MAX)      quant = SAT_MAX[DATA_W-1:0];
    else if (s < SAT_MIN) quant = SAT_MIN[DATA_W-1:0];
    else                  quant = s[DATA_W-1:0];
`else
    quant = DATA_W'((a + RND) >>> FRAC_W);
`endif
  endfunction

  state_t state_q, state_d;

  // Per-channel coefficient and delay-line storage
  logic [DATA_W-1:0] b0_q [CHANNELS];
  logic [DATA_W-1:0] b1_q [CHANNELS];
  logic [DATA_W-1:0] b2_q [CHANNELS];
  logic [DATA_W-1:0] a1_q [CHANNELS];
  logic [DATA_W-1:0] a2_q [CHANNELS];
  logic [DATA_W-1:0] sw1_q [CHANNELS];
  logic [DATA_W-1:0] sw2_q [CHANNELS];

  logic [DATA_W-1:0] x_q, cb0_q, cb1_q, cb2_q, ca1_q, ca2_q, ww1_q, ww2_q, w_q;
  logic [CH_W-1:0]   ch_q;
  logic              ok_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] y_q;
  logic [CH_W-1:0]   out_ch_q;

  logic              accept, in_ok, coef_hit;
  logic [DATA_W-1:0] mul_c, mul_s, q_d;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, x_ext;

  assign accept   = in_valid && in_ready;
  assign in_ok    = int'(in_ch) < CHANNELS;
  assign coef_hit = coef_we && (int'(coef_ch) < CHANNELS) && (coef_sel < 3'd5);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = FB1;
      FB1:     state_d = FB2;
      FB2:     state_d = FF0;
      FF0:     state_d = FF1;
      FF1:     state_d = FF2;
      FF2:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE) && ok_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        b0_q[i] <= COEF_ONE;
        b1_q[i] <= '0;
        b2_q[i] <= '0;
        a1_q[i] <= '0;
        a2_q[i] <= '0;
      end
    end else if (coef_hit) begin
      case (coef_sel)
        3'd0:    b0_q[coef_ch] <= coef_data;
        3'd1:    b1_q[coef_ch] <= coef_data;
        3'd2:    b2_q[coef_ch] <= coef_data;
        3'd3:    a1_q[coef_ch] <= coef_data;
        3'd4:    a2_q[coef_ch] <= coef_data;
        default: ;
      endcase
    end
  end

  // Delay line shifts only once the whole sample has completed
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sw1_q[i] <= '0;
        sw2_q[i] <= '0;
      end
    end else if (state_q == DONE && ok_q) begin
      sw1_q[ch_q] <= w_q;
      sw2_q[ch_q] <= ww1_q;
    end
  end

  always_comb begin
    mul_c = '0;
    mul_s = '0;
    case (state_q)
      FB1:     begin mul_c = ca1_q; mul_s = ww1_q; end
      FB2:     begin mul_c = ca2_q; mul_s = ww2_q; end
      FF0:     begin mul_c = cb0_q; mul_s = w_q;   end
      FF1:     begin mul_c = cb1_q; mul_s = ww1_q; end
      FF2:     begin mul_c = cb2_q; mul_s = ww2_q; end
      default: ;
    endcase
  end

  assign prod     = $signed(mul_c) * $signed(mul_s);
  assign prod_ext = ACC_W'(prod);
  assign x_ext    = ACC_W'($signed(x_q)) <<< FRAC_W;

  always_comb begin
    acc_d = acc_q;
    case (state_q)
      FB1:      acc_d = x_ext - prod_ext;
      FB2:      acc_d = acc_q - prod_ext;
      FF0:      acc_d = prod_ext;
      FF1, FF2: acc_d = acc_q + prod_ext;
      default:  ;
    endcase
  end

  assign q_d = quant(acc_d);

  // y/out_ch load on the FF2 edge so they are valid for the whole DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      ch_q     <= '0;
      ok_q     <= 1'b0;
      cb0_q    <= '0;
      cb1_q    <= '0;
      cb2_q    <= '0;
      ca1_q    <= '0;
      ca2_q    <= '0;
      ww1_q    <= '0;
      ww2_q    <= '0;
      w_q      <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      out_ch_q <= '0;
    end else begin
      if (accept) begin
        x_q   <= x;
        ch_q  <= in_ch;
        ok_q  <= in_ok;
        cb0_q <= b0_q[in_ch];
        cb1_q <= b1_q[in_ch];
        cb2_q <= b2_q[in_ch];
        ca1_q <= a1_q[in_ch];
        ca2_q <= a2_q[in_ch];
        ww1_q <= sw1_q[in_ch];
        ww2_q <= sw2_q[in_ch];
      end
      acc_q <= acc_d;
      if (state_q == FB2) w_q <= q_d;
      if (state_q == FF2 && ok_q) begin
        y_q      <= q_d;
        out_ch_q <= ch_q;
      end
    end
  end

  assign y      = y_q;
  assign out_ch = out_ch_q;

endmodule
